// File: rtl/cnn_fifo_pkg.sv
// ============================================================================
// Module   : cnn_fifo_pkg
// Brief    : Shared types and default sizes for the feature-map FIFO blocks.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cnn_fifo_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } arb_state_e;

    localparam int DEFAULT_DATA_W      = 16;
    localparam int DEFAULT_FIFO_DEPTH  = 64;
    localparam int DEFAULT_FIFO_ADDR_W = $clog2(DEFAULT_FIFO_DEPTH);

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
// ============================================================================
// Module   : rr_pick
// Brief    : Combinational round-robin picker; first request at or after rr_ptr.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick
    import cnn_fifo_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    rr_ptr,
    output logic [ID_W-1:0]    winner,
    output logic               any_req
);

    int idx;

    // Scan from the farthest offset down so the nearest requester wins last.
    always_comb begin
        winner  = '0;
        any_req = |req;
        idx     = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (req[idx]) begin
                winner = ID_W'(idx);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
// ============================================================================
// Module   : fifo_wr_arbiter
// Brief    : Burst round-robin arbiter sharing one FIFO write port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_wr_arbiter
    import cnn_fifo_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = DEFAULT_DATA_W,
    parameter int BURST_MAX = 16,
    parameter int ID_W      = $clog2(NUM_REQ),
    parameter int BCNT_W    = $clog2(BURST_MAX + 1)
) (
    input  logic                      w_clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    input  logic                      flush,
    input  logic                      fifo_full,
    output logic [NUM_REQ-1:0]        gnt,
    output logic                      fifo_w_en,
    output logic [DATA_W-1:0]         fifo_data,
    output logic [ID_W-1:0]           owner,
    output logic                      busy
);

    localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(BURST_MAX - 1);
    localparam logic [ID_W-1:0]   LAST_ID   = ID_W'(NUM_REQ - 1);

    arb_state_e        state_q, state_d;
    logic [ID_W-1:0]   owner_q, owner_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [BCNT_W-1:0] bcnt_q, bcnt_d;

    logic [ID_W-1:0]   pick_winner;
    logic              pick_any;
    logic              owner_req;
    logic              owner_last;
    logic [DATA_W-1:0] owner_word;
    logic              accept;
    logic              burst_end;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_pick (
        .req     (req),
        .rr_ptr  (rr_ptr_q),
        .winner  (pick_winner),
        .any_req (pick_any)
    );

    always_ff @(posedge w_clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            bcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            bcnt_q   <= bcnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        bcnt_d     = bcnt_q;
        gnt        = '0;
        fifo_data  = '0;
        owner_req  = req[owner_q];
        owner_last = req_last[owner_q];
        owner_word = req_data[int'(owner_q)*DATA_W +: DATA_W];
        accept     = 1'b0;
        burst_end  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    owner_d = pick_winner;
                    bcnt_d  = '0;
                    state_d = ST_BURST;
                end
            end
            ST_BURST: begin
                // Flush and a dropped request both suppress the write this cycle.
                accept = owner_req & ~fifo_full & ~flush;
                if (accept) begin
                    gnt[owner_q] = 1'b1;
                    fifo_data    = owner_word;
                    if (bcnt_q != '1) begin
                        bcnt_d = bcnt_q + BCNT_W'(1);
                    end
                end
                burst_end = flush | ~owner_req |
                            (accept & (owner_last | (bcnt_q == BCNT_LAST)));
                if (burst_end) begin
                    state_d  = ST_IDLE;
                    rr_ptr_d = (owner_q == LAST_ID) ? '0 : owner_q + ID_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign fifo_w_en = |gnt;
    assign owner     = owner_q;
    assign busy      = (state_q == ST_BURST);

endmodule

`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
// ============================================================================
// Module   : tb_fifo_wr_arbiter
// Brief    : Directed scoreboard bench for fifo_wr_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_wr_arbiter;

    localparam int NUM_REQ   = 4;
    localparam int DATA_W    = 16;
    localparam int BURST_MAX = 16;
    localparam int ID_W      = 2;
    localparam int BCNT_W    = 5;

    logic                      w_clk = 1'b0;
    logic                      reset;
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_last;
    logic                      flush;
    logic                      fifo_full;
    logic [NUM_REQ-1:0]        gnt;
    logic                      fifo_w_en;
    logic [DATA_W-1:0]         fifo_data;
    logic [ID_W-1:0]           owner;
    logic                      busy;

    fifo_wr_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .DATA_W    (DATA_W),
        .BURST_MAX (BURST_MAX),
        .ID_W      (ID_W),
        .BCNT_W    (BCNT_W)
    ) dut (
        .w_clk     (w_clk),
        .reset     (reset),
        .req       (req),
        .req_data  (req_data),
        .req_last  (req_last),
        .flush     (flush),
        .fifo_full (fifo_full),
        .gnt       (gnt),
        .fifo_w_en (fifo_w_en),
        .fifo_data (fifo_data),
        .owner     (owner),
        .busy      (busy)
    );

    always #5 w_clk = ~w_clk;

    typedef struct packed {
        logic [DATA_W-1:0] d;
        logic              last;
    } word_t;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [DATA_W-1:0] d;
    } exp_t;

    word_t              pq [NUM_REQ][$];
    exp_t               sb [$];
    logic [NUM_REQ-1:0] mask;
    int                 n_vec = 0;
    int                 n_err = 0;

    function automatic logic [NUM_REQ-1:0] oh(input int i);
        logic [NUM_REQ-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // last_at < 0 marks every word as last; last_at >= n marks none.
    task automatic load(input int id, input int n, input logic [DATA_W-1:0] base, input int last_at);
        word_t w;
        for (int k = 0; k < n; k++) begin
            w.d    = base + DATA_W'(k);
            w.last = (last_at < 0) || (k == last_at);
            pq[id].push_back(w);
        end
    endtask

    task automatic ex(input int id, input logic [DATA_W-1:0] d);
        exp_t e;
        e.id = ID_W'(id);
        e.d  = d;
        sb.push_back(e);
    endtask

    task automatic exr(input int id, input logic [DATA_W-1:0] base, input int n);
        for (int k = 0; k < n; k++) ex(id, base + DATA_W'(k));
    endtask

    task automatic drive();
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pq[i].size() > 0) begin
                req[i]                        = mask[i];
                req_data[i*DATA_W +: DATA_W]  = pq[i][0].d;
                req_last[i]                   = pq[i][0].last;
            end else begin
                req[i]                        = 1'b0;
                req_data[i*DATA_W +: DATA_W]  = '0;
                req_last[i]                   = 1'b0;
            end
        end
    endtask

    task automatic tick(input string tag, input logic [NUM_REQ-1:0] exp_gnt, input logic exp_busy);
        exp_t e;
        @(negedge w_clk);
        chk($sformatf("%s.gnt", tag), 32'(gnt), 32'(exp_gnt));
        chk($sformatf("%s.w_en", tag), 32'(fifo_w_en), 32'(|exp_gnt));
        chk($sformatf("%s.busy", tag), 32'(busy), 32'(exp_busy));
        if (fifo_w_en) begin
            n_vec++;
            assert (sb.size() > 0) else begin
                n_err++;
                $error("FAIL %s.sb: observed unexpected write %0h expected no write", tag, fifo_data);
            end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk($sformatf("%s.data", tag), 32'(fifo_data), 32'(e.d));
                chk($sformatf("%s.src", tag), 32'(gnt), 32'(oh(int'(e.id))));
            end
        end else begin
            chk($sformatf("%s.data0", tag), 32'(fifo_data), 32'd0);
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i] && pq[i].size() > 0) void'(pq[i].pop_front());
        end
        @(posedge w_clk);
        #1;
        drive();
    endtask

    initial begin
        int order [8];
        order = '{3, 0, 1, 2, 3, 0, 1, 2};
        reset     = 1'b0;
        flush     = 1'b0;
        fifo_full = 1'b0;
        mask      = '1;
        req       = '0;
        req_data  = '0;
        req_last  = '0;
        drive();

        // Reset state
        repeat (2) @(posedge w_clk);
        @(negedge w_clk);
        chk("rst.gnt", 32'(gnt), 32'd0);
        chk("rst.w_en", 32'(fifo_w_en), 32'd0);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.owner", 32'(owner), 32'd0);
        chk("rst.data", 32'(fifo_data), 32'd0);
        @(posedge w_clk);
        #1;
        reset = 1'b1;

        // Single requester, 3-word burst
        load(2, 3, 16'h2000, 2);
        exr(2, 16'h2000, 3);
        drive();
        tick("single.bubble", 4'b0000, 1'b0);
        repeat (3) tick("single.word", 4'b0100, 1'b1);
        tick("single.idle", 4'b0000, 1'b0);

        // Round robin with 1-word bursts, pointer starts at 3
        for (int i = 0; i < NUM_REQ; i++) load(i, 2, DATA_W'(16'h3000 + i*256), -1);
        for (int r = 0; r < 8; r++) ex(order[r], DATA_W'(16'h3000 + order[r]*256 + r/4));
        drive();
        for (int r = 0; r < 8; r++) begin
            tick("rr.bubble", 4'b0000, 1'b0);
            tick("rr.word", oh(order[r]), 1'b1);
        end

        // Burst limit, then requester 2, then back to 1
        load(1, 20, 16'h4000, 19);
        load(2, 1, 16'h4100, -1);
        exr(1, 16'h4000, 16);
        ex(2, 16'h4100);
        exr(1, 16'h4010, 4);
        drive();
        tick("lim.bubble", 4'b0000, 1'b0);
        chk("lim.owner", 32'(owner), 32'd1);
        repeat (16) tick("lim.word", 4'b0010, 1'b1);
        tick("lim.bubble2", 4'b0000, 1'b0);
        tick("lim.req2", 4'b0100, 1'b1);
        tick("lim.bubble3", 4'b0000, 1'b0);
        repeat (4) tick("lim.tail", 4'b0010, 1'b1);

        // Backpressure mid-burst must not disturb the burst count
        load(0, 17, 16'h5000, 16);
        exr(0, 16'h5000, 17);
        drive();
        tick("bp.bubble", 4'b0000, 1'b0);
        repeat (3) tick("bp.pre", 4'b0001, 1'b1);
        fifo_full = 1'b1;
        repeat (5) tick("bp.stall", 4'b0000, 1'b1);
        fifo_full = 1'b0;
        repeat (13) tick("bp.post", 4'b0001, 1'b1);
        tick("bp.bubble2", 4'b0000, 1'b0);
        tick("bp.last", 4'b0001, 1'b1);

        // Abandoned burst
        load(3, 5, 16'h6000, 4);
        exr(3, 16'h6000, 5);
        drive();
        tick("ab.bubble", 4'b0000, 1'b0);
        repeat (2) tick("ab.word", 4'b1000, 1'b1);
        mask[3] = 1'b0;
        drive();
        tick("ab.drop", 4'b0000, 1'b1);
        mask[3] = 1'b1;
        drive();
        tick("ab.rearb", 4'b0000, 1'b0);
        repeat (3) tick("ab.rest", 4'b1000, 1'b1);

        // Flush together with last
        load(1, 1, 16'h6100, -1);
        ex(1, 16'h6100);
        drive();
        tick("fl.bubble", 4'b0000, 1'b0);
        flush = 1'b1;
        tick("fl.flush", 4'b0000, 1'b1);
        flush = 1'b0;
        tick("fl.rearb", 4'b0000, 1'b0);
        tick("fl.word", 4'b0010, 1'b1);

        // Async reset mid-burst
        load(2, 4, 16'h7000, 3);
        load(0, 1, 16'h7100, -1);
        ex(2, 16'h7000);
        drive();
        tick("ar.bubble", 4'b0000, 1'b0);
        tick("ar.word", 4'b0100, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        chk("ar.gnt", 32'(gnt), 32'd0);
        chk("ar.w_en", 32'(fifo_w_en), 32'd0);
        chk("ar.busy", 32'(busy), 32'd0);
        chk("ar.owner", 32'(owner), 32'd0);
        @(posedge w_clk);
        #3;
        reset = 1'b1;
        ex(0, 16'h7100);
        exr(2, 16'h7001, 3);
        tick("ar.bubble2", 4'b0000, 1'b0);
        tick("ar.req0", 4'b0001, 1'b1);
        tick("ar.bubble3", 4'b0000, 1'b0);
        repeat (3) tick("ar.rest", 4'b0100, 1'b1);
        tick("ar.idle", 4'b0000, 1'b0);

        chk("sb.empty", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
